ddr_mem_responder: RTL

//  Memory-side responder for the controller's DDR4 command bus: decodes cs_n/act_n/ras_n/cas_n/we_n each CK_t,

---
 rtl/ddr_pkg.sv | 64 ++++++
 rtl/ddr_bank_tracker.sv | 82 ++++++++
 rtl/ddr_mem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types, timing defaults and command decode
// for the DDR4 command-bus memory responder.
package ddr_pkg;

    localparam int CNT_W     = 8;
    localparam int DEF_CL    = 11;
    localparam int DEF_CWL   = 9;
    localparam int DEF_BL    = 8;
    localparam int DEF_T_RCD = 11;
    localparam int DEF_T_RP  = 11;
    localparam int DEF_T_RC  = 39;
    localparam int DEF_T_RFC = 208;
    localparam int DEF_T_MOD = 24;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
    } ddr_cmd_t;

    typedef enum logic [1:0] {
        BANK_IDLE, BANK_ACTIVATING, BANK_ACTIVE, BANK_PRECHARGING
    } bank_state_t;

    typedef enum logic [1:0] {
        MEM_READY, MEM_REFRESH, MEM_MRS
    } mem_state_t;

    typedef enum logic [2:0] {
        V_NONE           = 3'd0,
        V_ACT_NOT_IDLE   = 3'd1,
        V_NOT_ACTIVE     = 3'd2,
        V_PRE_ACTIVATING = 3'd3,
        V_NOT_IDLE       = 3'd4,
        V_TRC            = 3'd5,
        V_BUSY           = 3'd6,
        V_BURST          = 3'd7
    } viol_code_t;

    function automatic ddr_cmd_t decode_cmd(
        input logic cs_n,
        input logic act_n,
        input logic ras_n,
        input logic cas_n,
        input logic we_n
    );
        ddr_cmd_t c;
        c = CMD_NOP;
        if (!cs_n) begin
            if (!act_n) begin
                c = CMD_ACT;
            end else begin
                case ({ras_n, cas_n, we_n})
                    3'b000:  c = CMD_MRS;
                    3'b001:  c = CMD_REF;
                    3'b010:  c = CMD_PRE;
                    3'b101:  c = CMD_RD;
                    3'b100:  c = CMD_WR;
                    default: c = CMD_NOP;
                endcase
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Per-bank state machine: activate/precharge timers,
// tRC window, pending auto-precharge and open row.
module ddr_bank_tracker
    import ddr_pkg::*;
#(
    parameter int ROW_W = 17,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RC  = DEF_T_RC
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             act_i,
    input  logic             pre_i,
    input  logic             rdwr_i,
    input  logic             ap_i,
    input  logic [CNT_W-1:0] ap_dly_i,
    input  logic [ROW_W-1:0] row_i,
    output bank_state_t      state_o,
    output logic             active_o,
    output logic             rc_ok_o,
    output logic [ROW_W-1:0] row_o
);

    bank_state_t      state_q;
    logic [CNT_W-1:0] cnt_q, rc_q, ap_q;
    logic             ap_pend_q;
    logic [ROW_W-1:0] row_q;

    // Expiry is visible to a command arriving on the same edge.
    always_comb begin
        state_o = state_q;
        if (cnt_q == '0) begin
            if (state_q == BANK_ACTIVATING)  state_o = BANK_ACTIVE;
            if (state_q == BANK_PRECHARGING) state_o = BANK_IDLE;
        end
    end

    assign active_o = (state_q == BANK_ACTIVE);
    assign rc_ok_o  = (rc_q == '0);
    assign row_o    = row_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BANK_IDLE;
            cnt_q     <= '0;
            rc_q      <= '0;
            ap_q      <= '0;
            ap_pend_q <= 1'b0;
            row_q     <= '0;
        end else begin
            state_q <= state_o;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (rc_q != '0)  rc_q  <= rc_q - 1'b1;
            if (ap_pend_q) begin
                if (ap_q == '0) begin
                    ap_pend_q <= 1'b0;
                    state_q   <= BANK_PRECHARGING;
                    cnt_q     <= CNT_W'(T_RP - 1);
                end else begin
                    ap_q <= ap_q - 1'b1;
                end
            end
            if (act_i) begin
                state_q <= BANK_ACTIVATING;
                cnt_q   <= CNT_W'(T_RCD - 1);
                rc_q    <= CNT_W'(T_RC - 1);
                row_q   <= row_i;
            end
            if (pre_i) begin
                state_q   <= BANK_PRECHARGING;
                cnt_q     <= CNT_W'(T_RP - 1);
                ap_pend_q <= 1'b0;
            end
            if (rdwr_i && ap_i) begin
                ap_pend_q <= 1'b1;
                ap_q      <= ap_dly_i;
            end
        end
    end

endmodule

// File: rtl/ddr_mem_responder.sv
// DDR4 command-bus responder: decode, global FSM,
// read/write burst pipelines and violation reporting.
module ddr_mem_responder
    import ddr_pkg::*;
#(
    parameter int BG_W   = 2,
    parameter int BA_W   = 2,
    parameter int ROW_W  = 17,
    parameter int COL_W  = 10,
    parameter int DATA_W = 64,
    parameter int CL     = DEF_CL,
    parameter int CWL    = DEF_CWL,
    parameter int BL     = DEF_BL,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RC   = DEF_T_RC,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_MOD  = DEF_T_MOD,
    localparam int NBANK = 2 ** (BG_W + BA_W)
) (
    input  logic              CK_t,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [BG_W-1:0]   bg,
    input  logic [BA_W-1:0]   ba,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_window,
    output logic [DATA_W-1:0] last_wr,
    output logic [NBANK-1:0]  bank_open,
    output logic              mem_busy,
    output logic              viol,
    output logic [2:0]        viol_code
);

    localparam int SEL_W = BG_W + BA_W;
    localparam int BW    = $clog2(BL / 2);

    ddr_cmd_t         cmd;
    logic [SEL_W-1:0] sel;
    logic [ROW_W-1:0] act_row;
    logic [DATA_W-1:0] rd_base;
    bank_state_t      bstate [NBANK];
    logic [ROW_W-1:0] brow [NBANK];
    logic [NBANK-1:0] rc_ok, act_b, pre_b, rdwr_b;
    logic             all_idle, any_activating, mem_ready;
    logic             act_ok, pre_ok, prea_ok, rd_ok, wr_ok, ref_ok, mrs_ok;
    logic [CNT_W-1:0] ap_dly;
    viol_code_t       vcode;

    mem_state_t        mstate_q;
    logic [CNT_W-1:0]  mcnt_q, burst_q;
    logic              viol_q;
    viol_code_t        viol_code_q;
    logic [CL-1:0]     rpipe_v_q;
    logic [DATA_W-1:0] rpipe_d_q [CL];
    logic [CWL-1:0]    wpipe_q;
    logic              rd_valid_q, wr_window_q;
    logic [DATA_W-1:0] rd_data_q, rbase_q, last_wr_q;
    logic [BW-1:0]     rbeat_q, wbeat_q;

    assign cmd       = decode_cmd(cs_n, act_n, ras_n, cas_n, we_n);
    assign sel       = {bg, ba};
    assign act_row   = ROW_W'({ras_n, cas_n, we_n, addr[13:0]});
    assign rd_base   = DATA_W'({bg, ba, brow[sel], addr[COL_W-1:0]});
    assign mem_ready = (mstate_q == MEM_READY) || (mcnt_q == '0);
    assign ap_dly    = rd_ok ? CNT_W'(CL + BL - 2) : CNT_W'(CWL + BL - 2);

    always_comb begin
        all_idle       = 1'b1;
        any_activating = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (bstate[i] != BANK_IDLE)       all_idle       = 1'b0;
            if (bstate[i] == BANK_ACTIVATING) any_activating = 1'b1;
        end
    end

    // A violating command is dropped: no *_ok strobe fires.
    always_comb begin
        vcode   = V_NONE;
        act_ok  = 1'b0;
        pre_ok  = 1'b0;
        prea_ok = 1'b0;
        rd_ok   = 1'b0;
        wr_ok   = 1'b0;
        ref_ok  = 1'b0;
        mrs_ok  = 1'b0;
        if (cmd != CMD_NOP && !mem_ready) begin
            vcode = V_BUSY;
        end else begin
            case (cmd)
                CMD_ACT: begin
                    if (bstate[sel] != BANK_IDLE) vcode = V_ACT_NOT_IDLE;
                    else if (!rc_ok[sel])         vcode = V_TRC;
                    else                          act_ok = 1'b1;
                end
                CMD_RD, CMD_WR: begin
                    if (bstate[sel] != BANK_ACTIVE) begin
                        vcode = V_NOT_ACTIVE;
                    end else if (burst_q != '0) begin
                        vcode = V_BURST;
                    end else begin
                        rd_ok = (cmd == CMD_RD);
                        wr_ok = (cmd == CMD_WR);
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) begin
                        if (any_activating) vcode = V_PRE_ACTIVATING;
                        else                prea_ok = 1'b1;
                    end else if (bstate[sel] == BANK_ACTIVATING) begin
                        vcode = V_PRE_ACTIVATING;
                    end else begin
                        pre_ok = (bstate[sel] == BANK_ACTIVE);
                    end
                end
                CMD_REF, CMD_MRS: begin
                    if (!all_idle) begin
                        vcode = V_NOT_IDLE;
                    end else begin
                        ref_ok = (cmd == CMD_REF);
                        mrs_ok = (cmd == CMD_MRS);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic hit;
        assign hit       = (sel == SEL_W'(i));
        assign act_b[i]  = act_ok && hit;
        assign pre_b[i]  = (pre_ok && hit) || (prea_ok && bstate[i] == BANK_ACTIVE);
        assign rdwr_b[i] = (rd_ok || wr_ok) && hit;

        ddr_bank_tracker #(
            .ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC)
        ) u_bank (
            .clk_i    (CK_t),
            .rst_i    (reset),
            .act_i    (act_b[i]),
            .pre_i    (pre_b[i]),
            .rdwr_i   (rdwr_b[i]),
            .ap_i     (addr[10]),
            .ap_dly_i (ap_dly),
            .row_i    (act_row),
            .state_o  (bstate[i]),
            .active_o (bank_open[i]),
            .rc_ok_o  (rc_ok[i]),
            .row_o    (brow[i])
        );
    end

    always_ff @(posedge CK_t) begin
        rpipe_d_q[0] <= rd_base;
        for (int i = 1; i < CL; i++) rpipe_d_q[i] <= rpipe_d_q[i-1];
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            mstate_q    <= MEM_READY;
            mcnt_q      <= '0;
            burst_q     <= '0;
            viol_q      <= 1'b0;
            viol_code_q <= V_NONE;
            rpipe_v_q   <= '0;
            wpipe_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rbase_q     <= '0;
            rbeat_q     <= '0;
            wr_window_q <= 1'b0;
            wbeat_q     <= '0;
            last_wr_q   <= '0;
        end else begin
            viol_q <= (vcode != V_NONE);
            if (viol_code_q == V_NONE) viol_code_q <= vcode;

            if (mstate_q != MEM_READY && mcnt_q == '0) mstate_q <= MEM_READY;
            if (mcnt_q != '0) mcnt_q <= mcnt_q - 1'b1;
            if (ref_ok) begin
                mstate_q <= MEM_REFRESH;
                mcnt_q   <= CNT_W'(T_RFC - 1);
            end
            if (mrs_ok) begin
                mstate_q <= MEM_MRS;
                mcnt_q   <= CNT_W'(T_MOD - 1);
            end

            if (burst_q != '0) burst_q <= burst_q - 1'b1;
            if (rd_ok || wr_ok) burst_q <= CNT_W'(BL / 2 - 1);

            // A new burst head overrides the tail, giving gapless beats.
            rpipe_v_q <= {rpipe_v_q[CL-2:0], rd_ok};
            if (rpipe_v_q[CL-1]) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= rpipe_d_q[CL-1];
                rbase_q    <= rpipe_d_q[CL-1];
                rbeat_q    <= BW'(1);
            end else if (rbeat_q != '0) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= rbase_q ^ DATA_W'(rbeat_q);
                rbeat_q    <= rbeat_q + 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end

            wpipe_q <= {wpipe_q[CWL-2:0], wr_ok};
            if (wr_window_q) last_wr_q <= wr_data;
            if (wpipe_q[CWL-1]) begin
                wr_window_q <= 1'b1;
                wbeat_q     <= BW'(1);
            end else if (wbeat_q != '0) begin
                wr_window_q <= 1'b1;
                wbeat_q     <= wbeat_q + 1'b1;
            end else begin
                wr_window_q <= 1'b0;
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_window = wr_window_q;
    assign last_wr   = last_wr_q;
    assign mem_busy  = (mstate_q != MEM_READY);
    assign viol      = viol_q;
    assign viol_code = viol_code_q;

endmodule
